write_back_unit_p: RTL and testbench

//  Parametrised registered write-back stage: MEM/WB pipeline register plus result select.

---
 rtl/write_back_unit_p.sv | 107 ++++++++++
 tb/tb_write_back_unit_p.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/write_back_unit_p.sv
// write_back_unit_p: registered MEM/WB write-back stage.
//   Picks one of four result sources (ALU, extended load data, PC+4, immediate) and registers
//   it together with the destination register and write enable. A stall holds the stage, a
//   flush turns the held entry into a bubble, and a saturating counter counts retired
//   instructions.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   stall, flush            hold stage / replace captured entry with a bubble (flush wins)
//   in_valid, WBSel, WR, RD memory-stage bundle control
//   LdMode                  load extension: 001 sb, 010 ub, 011 sh, 100 uh, others full word
//   ALU_result, MEM_Data,   result sources; ALU_result low bits also give the load byte offset
//   PC_plus, Imm
//   WBData, RD_out, WR_out  registered register-file write port
//   wb_valid, retired       stage holds a real instruction / saturating retired count
module write_back_unit_p #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        WBSel,
  input  logic              WR,
  input  logic [REG_AW-1:0] RD,
  input  logic [2:0]        LdMode,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] MEM_Data,
  input  logic [DATA_W-1:0] PC_plus,
  input  logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] WBData,
  output logic [REG_AW-1:0] RD_out,
  output logic              WR_out,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);

  logic [OffW-1:0]   off;
  logic [OffW-1:0]   half_off;
  logic [DATA_W-1:0] byte_sh;
  logic [DATA_W-1:0] half_sh;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] sel_val;
  logic              wr_next;
  logic              capture;

  always_comb begin
    off      = ALU_result[OffW-1:0];
    half_off = {off[OffW-1:1], 1'b0};
    // Little-endian lanes: shift the addressed lane down to bit 0.
    byte_sh  = MEM_Data >> {off, 3'b000};
    half_sh  = MEM_Data >> {half_off, 3'b000};
    byte_val = byte_sh[7:0];
    half_val = half_sh[15:0];

    load_val = MEM_Data;
    case (LdMode)
      3'b001:  load_val = {{(DATA_W - 8){byte_val[7]}}, byte_val};
      3'b010:  load_val = {{(DATA_W - 8){1'b0}}, byte_val};
      3'b011:  load_val = {{(DATA_W - 16){half_val[15]}}, half_val};
      3'b100:  load_val = {{(DATA_W - 16){1'b0}}, half_val};
      default: load_val = MEM_Data;
    endcase

    sel_val = ALU_result;
    unique case (WBSel)
      2'd0: sel_val = ALU_result;
      2'd1: sel_val = load_val;
      2'd2: sel_val = PC_plus;
      2'd3: sel_val = Imm;
      default: sel_val = ALU_result;
    endcase

    wr_next = in_valid & WR & ~((ZERO_REG != 0) && (RD == '0));
    capture = ~flush & ~stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WBData   <= '0;
      RD_out   <= '0;
      WR_out   <= 1'b0;
      wb_valid <= 1'b0;
      retired  <= '0;
    end else if (flush) begin
      // Bubble: kill the write but keep data/address visible.
      WR_out   <= 1'b0;
      wb_valid <= 1'b0;
    end else if (capture) begin
      WBData   <= sel_val;
      RD_out   <= RD;
      WR_out   <= wr_next;
      wb_valid <= in_valid;
      if (in_valid && (retired != '1)) begin
        retired <= retired + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_back_unit_p.sv
module tb_write_back_unit_p;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [1:0]  wbsel;
  logic        wr;
  logic [3:0]  rd;
  logic [2:0]  ldmode;
  logic [31:0] alu;
  logic [31:0] mem;
  logic [31:0] pc;
  logic [31:0] imm;

  logic [31:0] wb_data, wb_data_nz, wb_data_c4;
  logic [3:0]  rd_out, rd_out_nz, rd_out_c4;
  logic        wr_out, wr_out_nz, wr_out_c4;
  logic        wb_valid, wb_valid_nz, wb_valid_c4;
  logic [15:0] retired, retired_nz;
  logic [3:0]  retired_c4;

  int unsigned passed;
  int unsigned total;
  logic [15:0] exp_ret;

  write_back_unit_p #(.DATA_W(32), .REG_AW(4), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .WBSel(wbsel), .WR(wr), .RD(rd), .LdMode(ldmode), .ALU_result(alu), .MEM_Data(mem),
    .PC_plus(pc), .Imm(imm), .WBData(wb_data), .RD_out(rd_out), .WR_out(wr_out),
    .wb_valid(wb_valid), .retired(retired)
  );

  write_back_unit_p #(.DATA_W(32), .REG_AW(4), .ZERO_REG(0), .CNT_W(16)) dut_nz (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .WBSel(wbsel), .WR(wr), .RD(rd), .LdMode(ldmode), .ALU_result(alu), .MEM_Data(mem),
    .PC_plus(pc), .Imm(imm), .WBData(wb_data_nz), .RD_out(rd_out_nz), .WR_out(wr_out_nz),
    .wb_valid(wb_valid_nz), .retired(retired_nz)
  );

  write_back_unit_p #(.DATA_W(32), .REG_AW(4), .ZERO_REG(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .WBSel(wbsel), .WR(wr), .RD(rd), .LdMode(ldmode), .ALU_result(alu), .MEM_Data(mem),
    .PC_plus(pc), .Imm(imm), .WBData(wb_data_c4), .RD_out(rd_out_c4), .WR_out(wr_out_c4),
    .wb_valid(wb_valid_c4), .retired(retired_c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] s, input logic w, input logic [3:0] r,
                       input logic [2:0] l, input logic [31:0] a, input logic [31:0] m,
                       input logic [31:0] p, input logic [31:0] i);
    in_valid = v; wbsel = s; wr = w; rd = r; ldmode = l;
    alu = a; mem = m; pc = p; imm = i;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (wb_data !== 32'h0) $display("FAIL rst_wbdata got %h want 0", wb_data); else passed++;
    total++; if (retired !== 16'h0) $display("FAIL rst_retired got %0d want 0", retired); else passed++;
    reset = 1'b0;
    drive(1'b1, 2'd0, 1'b1, 4'd9, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (retired !== 16'd1) $display("FAIL pre_rst_retired got %0d want 1", retired); else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({wb_data, rd_out, wr_out, wb_valid, retired} !== 54'h0)
      $display("FAIL midrst_outputs got %h/%0d/%b/%b/%0d want all 0",
               wb_data, rd_out, wr_out, wb_valid, retired);
    else passed++;
    tick();
    total++;
    if ({wb_data, wb_valid, retired} !== 49'h0)
      $display("FAIL rst_held got %h/%b/%0d want all 0", wb_data, wb_valid, retired);
    else passed++;
    reset = 1'b0;
    exp_ret = 16'd0;
  endtask

  task automatic test_alu();
    drive(1'b1, 2'd0, 1'b1, 4'd5, 3'b001, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0);
    tick();
    exp_ret++;
    total++; if (wb_data !== 32'h1234_5678) $display("FAIL alu_wbdata got %h want 12345678", wb_data); else passed++;
    total++; if (rd_out !== 4'd5) $display("FAIL alu_rd got %0d want 5", rd_out); else passed++;
    total++; if (wr_out !== 1'b1) $display("FAIL alu_wr got %b want 1", wr_out); else passed++;
    total++; if (wb_valid !== 1'b1) $display("FAIL alu_valid got %b want 1", wb_valid); else passed++;
    total++; if (retired !== exp_ret) $display("FAIL alu_retired got %0d want %0d", retired, exp_ret); else passed++;
  endtask

  task automatic test_load();
    logic [31:0] vec_a [8];
    logic [2:0]  vec_l [8];
    logic [31:0] vec_e [8];
    vec_a = '{32'h3, 32'h3, 32'h2, 32'h3, 32'h0, 32'h0, 32'h1, 32'h1};
    vec_l = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b000, 3'b001, 3'b111};
    vec_e = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'hFFFF_80FF,
              32'h0000_7F01, 32'h80FF_7F01, 32'h0000_007F, 32'h80FF_7F01};
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'd1, 1'b1, 4'd3, vec_l[k], vec_a[k], 32'h80FF_7F01, 32'h0, 32'h0);
      tick();
      exp_ret++;
      total++;
      if (wb_data !== vec_e[k])
        $display("FAIL load_%0d got %h want %h", k, wb_data, vec_e[k]);
      else passed++;
    end
    total++; if (retired !== exp_ret) $display("FAIL load_retired got %0d want %0d", retired, exp_ret); else passed++;
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 2'd0, 1'b1, 4'd0, 3'b000, 32'h0000_00AA, 32'h0, 32'h0, 32'h0);
    tick();
    exp_ret++;
    total++; if (wr_out !== 1'b0) $display("FAIL zr_wr got %b want 0", wr_out); else passed++;
    total++; if (wb_valid !== 1'b1) $display("FAIL zr_valid got %b want 1", wb_valid); else passed++;
    total++; if (retired !== exp_ret) $display("FAIL zr_retired got %0d want %0d", retired, exp_ret); else passed++;
    total++; if (wr_out_nz !== 1'b1) $display("FAIL nz_wr got %b want 1", wr_out_nz); else passed++;
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 2'd3, 1'b1, 4'd7, 3'b000, 32'h0, 32'h0, 32'h0, 32'hCAFE_BABE);
    tick();
    exp_ret++;
    total++; if (wb_data !== 32'hCAFE_BABE) $display("FAIL imm_wbdata got %h want cafebabe", wb_data); else passed++;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd0, 1'b1, 4'(k + 1), 3'b000, 32'(k + 100), 32'h0, 32'h0, 32'h0);
      tick();
      total++;
      if (wb_data !== 32'hCAFE_BABE || rd_out !== 4'd7 || wb_valid !== 1'b1 || retired !== exp_ret)
        $display("FAIL stall_%0d got %h/%0d/%b/%0d want cafebabe/7/1/%0d",
                 k, wb_data, rd_out, wb_valid, retired, exp_ret);
      else passed++;
    end
    flush = 1'b1;
    tick();
    total++; if (wb_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", wb_valid); else passed++;
    total++; if (wr_out !== 1'b0) $display("FAIL flush_wr got %b want 0", wr_out); else passed++;
    total++;
    if (wb_data !== 32'hCAFE_BABE || rd_out !== 4'd7 || retired !== exp_ret)
      $display("FAIL flush_hold got %h/%0d/%0d want cafebabe/7/%0d", wb_data, rd_out, retired, exp_ret);
    else passed++;
    stall = 1'b0;
    flush = 1'b0;
    // Non-valid capture: data loads, no write, counter unchanged.
    drive(1'b0, 2'd0, 1'b1, 4'd2, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 32'h0);
    tick();
    total++;
    if (wb_data !== 32'h55 || wb_valid !== 1'b0 || wr_out !== 1'b0 || retired !== exp_ret)
      $display("FAIL bubble got %h/%b/%b/%0d want 55/0/0/%0d", wb_data, wb_valid, wr_out, retired, exp_ret);
    else passed++;
  endtask

  task automatic test_sel();
    drive(1'b1, 2'd2, 1'b1, 4'd1, 3'b001, 32'h3, 32'h80FF_7F01, 32'h0040_0004, 32'hABCD_0000);
    tick();
    total++; if (wb_data !== 32'h0040_0004) $display("FAIL sel_pc got %h want 00400004", wb_data); else passed++;
    drive(1'b1, 2'd3, 1'b1, 4'd1, 3'b001, 32'h3, 32'h80FF_7F01, 32'h0040_0004, 32'hABCD_0000);
    tick();
    total++; if (wb_data !== 32'hABCD_0000) $display("FAIL sel_imm got %h want abcd0000", wb_data); else passed++;
  endtask

  task automatic test_back_to_back();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2'd0, 1'b1, 4'd4, 3'b000, 32'(k), 32'h0, 32'h0, 32'h0);
      tick();
      if (k == 14) begin
        total++; if (retired_c4 !== 4'd15) $display("FAIL sat_reach got %0d want 15", retired_c4); else passed++;
      end
    end
    total++; if (retired_c4 !== 4'd15) $display("FAIL sat_hold got %0d want 15", retired_c4); else passed++;
    total++; if (retired !== 16'd20) $display("FAIL wide_count got %0d want 20", retired); else passed++;
    total++; if (wb_data_c4 !== 32'd19) $display("FAIL b2b_last got %h want 13", wb_data_c4); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    exp_ret = 16'd0;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 4'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_alu();
    test_load();
    test_zero_reg();
    test_stall_flush();
    test_sel();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
